// File: rtl/buzzer_tone_gen.sv
// Square-wave buzzer driver: plays do..si in three octaves from a half-period table,
// with a silent articulation gap between different notes and an immediate mute.
module buzzer_tone_gen #(
   parameter int unsigned GAP_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] note,
   input  logic [1:0] octave,
   input  logic       mute,
   output logic       speaker,
   output logic       playing,
   output logic [3:0] cur_note,
   output logic [1:0] cur_octave,
   output logic       period_tick
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TONE = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [31:0] GAP_LAST = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);

   // Middle-octave table scaled by octave: low doubles, high halves (truncating).
   function automatic logic [18:0] half_for(input logic [3:0] n, input logic [1:0] oct);
      logic [18:0] base;
      case (n)
         4'd1:    base = 19'd191110;
         4'd2:    base = 19'd170265;
         4'd3:    base = 19'd151685;
         4'd4:    base = 19'd143172;
         4'd5:    base = 19'd127551;
         4'd6:    base = 19'd113636;
         4'd7:    base = 19'd101239;
         default: base = 19'd0;
      endcase
      case (oct)
         2'd0:    half_for = base << 1;
         2'd1:    half_for = base;
         default: half_for = base >> 1;
      endcase
   endfunction

   function automatic logic [1:0] clamp_oct(input logic [1:0] oct);
      clamp_oct = (oct == 2'd3) ? 2'd2 : oct;
   endfunction

   state_t      state_r;
   logic [3:0]  note_r;
   logic [1:0]  octave_r;
   logic        mute_r;
   logic [18:0] half_r;
   logic [18:0] cnt_r;
   logic [31:0] gap_cnt_r;

   logic        req_valid_s;
   logic [1:0]  req_oct_s;
   logic [18:0] req_half_s;
   logic        same_s;
   logic        half_end_s;
   logic        gap_end_s;

   assign req_valid_s = (note_r >= 4'd1) && (note_r <= 4'd7);
   assign req_oct_s   = clamp_oct(octave_r);
   assign req_half_s  = half_for(note_r, req_oct_s);
   assign same_s      = (note_r == cur_note) && (req_oct_s == cur_octave);
   assign half_end_s  = (cnt_r == (half_r - 19'd1));
   assign gap_end_s   = (gap_cnt_r == GAP_LAST);

   // Input stage, tone/gap state machine and all registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r     <= IDLE;
         note_r      <= 4'd0;
         octave_r    <= 2'd0;
         mute_r      <= 1'b0;
         half_r      <= 19'd0;
         cnt_r       <= 19'd0;
         gap_cnt_r   <= 32'd0;
         speaker     <= 1'b0;
         playing     <= 1'b0;
         cur_note    <= 4'd0;
         cur_octave  <= 2'd0;
         period_tick <= 1'b0;
      end else begin
         note_r      <= note;
         octave_r    <= octave;
         mute_r      <= mute;
         period_tick <= 1'b0;
         if (mute_r) begin
            state_r   <= IDLE;
            cnt_r     <= 19'd0;
            gap_cnt_r <= 32'd0;
            speaker   <= 1'b0;
            playing   <= 1'b0;
            cur_note  <= 4'd0;
         end else begin
            case (state_r)
               IDLE: begin
                  if (req_valid_s) begin
                     state_r    <= TONE;
                     half_r     <= req_half_s;
                     cnt_r      <= 19'd0;
                     speaker    <= 1'b1;
                     playing    <= 1'b1;
                     cur_note   <= note_r;
                     cur_octave <= req_oct_s;
                  end else begin
                     speaker  <= 1'b0;
                     playing  <= 1'b0;
                     cur_note <= 4'd0;
                  end
               end
               TONE: begin
                  if (!half_end_s) begin
                     cnt_r <= cnt_r + 19'd1;
                  end else if (speaker) begin
                     cnt_r   <= 19'd0;
                     speaker <= 1'b0;
                  end else begin
                     // Full period complete: the only point where a new request is honoured.
                     cnt_r       <= 19'd0;
                     period_tick <= 1'b1;
                     if (same_s) begin
                        speaker <= 1'b1;
                     end else if (!req_valid_s) begin
                        state_r  <= IDLE;
                        speaker  <= 1'b0;
                        playing  <= 1'b0;
                        cur_note <= 4'd0;
                     end else if (GAP_CYCLES == 0) begin
                        half_r     <= req_half_s;
                        speaker    <= 1'b1;
                        cur_note   <= note_r;
                        cur_octave <= req_oct_s;
                     end else begin
                        state_r   <= GAP;
                        gap_cnt_r <= 32'd0;
                        speaker   <= 1'b0;
                        playing   <= 1'b0;
                        cur_note  <= 4'd0;
                     end
                  end
               end
               GAP: begin
                  speaker <= 1'b0;
                  if (!gap_end_s) begin
                     gap_cnt_r <= gap_cnt_r + 32'd1;
                  end else if (req_valid_s) begin
                     state_r    <= TONE;
                     gap_cnt_r  <= 32'd0;
                     half_r     <= req_half_s;
                     cnt_r      <= 19'd0;
                     speaker    <= 1'b1;
                     playing    <= 1'b1;
                     cur_note   <= note_r;
                     cur_octave <= req_oct_s;
                  end else begin
                     state_r   <= IDLE;
                     gap_cnt_r <= 32'd0;
                  end
               end
               default: begin
                  state_r  <= IDLE;
                  speaker  <= 1'b0;
                  playing  <= 1'b0;
                  cur_note <= 4'd0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/buzzer_tone_gen.md
BUZZER_TONE_GEN -- requirements
Module: buzzer_tone_gen

Interface
REQ-001 Parameter GAP_CYCLES, default 1000000, silent articulation gap between two different notes, in clk cycles (0 = no gap).
REQ-002 clk  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-low.
REQ-004 note  input  4  requested note: 1..7 = do..si; all other values = rest.
REQ-005 octave  input  2  requested octave: 0 low, 1 middle, 2 high, 3 same as 2.
REQ-006 mute  input  1  active-high immediate silence.
REQ-007 speaker  output  1  square-wave drive to buzzer.
REQ-008 playing  output  1  high while in TONE.
REQ-009 cur_note  output  4  note actually sounding; 0 when not in TONE.
REQ-010 cur_octave  output  2  octave actually sounding, clamped to 0..2.
REQ-011 period_tick  output  1  one-cycle pulse at each completed full tone period.

Function
REQ-012 note, octave and mute are registered once (input stage); all decisions use the registered copies ("request").
REQ-013 Middle-octave half-period table, in cycles: 1=191110, 2=170265, 3=151685, 4=143172, 5=127551, 6=113636, 7=101239.
REQ-014 Octave 0 uses table value shifted left by 1; octave 1 uses the table value; octave 2/3 use it shifted right by 1 (truncating). The half-period counter is 19 bits.
REQ-015 States: IDLE, TONE, GAP.
REQ-016 In IDLE, speaker=0 and playing=0; a valid request with mute=0 enters TONE on the next edge, loading cur_note/cur_octave and the half-period, with speaker=1 and the counter at 0.
REQ-017 In TONE, the counter increments each cycle. At count == half-1, speaker toggles and the counter clears.
REQ-018 A high-to-low toggle ends the first half. A low-to-high toggle ends the full period, and period_tick=1 in that same cycle.
REQ-019 At each period end, the request is compared to cur_note/cur_octave (clamped):
  - equal: continue.
  - rest: go to IDLE with speaker=0.
  - different valid note: go to GAP with speaker=0.
REQ-020 Request changes mid-period are ignored until the period end; worst-case latency is one full period plus 2 cycles.
REQ-021 Registered mute=1 in any state forces IDLE on the next edge, with speaker=0, playing=0 and cur_note=0. Mute overrides a coincident period end.
REQ-022 GAP counts GAP_CYCLES cycles with speaker=0.
  - At the end, a valid request with mute=0 enters TONE, sampling the request at that cycle; otherwise the block goes to IDLE.
  - If GAP_CYCLES=0, the different-note transition goes directly to TONE with the new note.
REQ-023 A rest during GAP does not abort GAP; it is evaluated at GAP end.
REQ-024 Changing only the octave counts as a different note.
REQ-025 All outputs are registered; no combinational path from input to output.

Reset
REQ-026 When reset=0 at a clk edge: state=IDLE, speaker=0, playing=0, cur_note=0, cur_octave=0, period_tick=0, counters=0, and input registers cleared to rest. Reset overrides all other activity, including mid-tone and mid-gap.

Verification
REQ-027 Hold reset=0 for 3 cycles with note=6, octave=1 -> speaker=0, playing=0 throughout; after release, playing=1 exactly 2 cycles later.
REQ-028 note=6, octave=1 from IDLE -> speaker high 113636 cycles then low 113636; period_tick every 227272 cycles; cur_note=6, cur_octave=1.
REQ-029 note=1 with octave=0, then 2, then 3 (each from IDLE) -> half-periods 382220 / 95555 / 95555; cur_octave=0 / 2 / 2.
REQ-030 GAP_CYCLES=1000; switch note 6->5 at mid-high of a period -> current 227272-cycle period completes, then 1000 cycles low, then half-period 127551.
REQ-031 mute=1 mid-tone -> speaker=0, playing=0 within 2 cycles of the input change; mute=0 with note=3, octave=1 held -> TONE resumes at half-period 151685.
REQ-032 Set note 6->0 mid-period, then 6->8 mid-period -> in each case the period completes, period_tick fires, then IDLE with speaker=0 and cur_note=0.
